des_stream_controller: RTL and testbench

Single-clock sequencer between the input block FIFO, the pipelined DES core and the output block FIFO. It loads the key and mode into the DES core, then pops 64-bit blocks from the input FIFO and issues them into the core. It generates the output-FIFO write strobe by tracking each issued block through the fixed pipeline latency. A credit counter guarantees that blocks in flight plus blocks already queued in the output FIFO never exceed the output FIFO depth, so no result is ever dropped.

---
 rtl/des_stream_controller.sv | 123 ++++++++++++
 tb/tb_des_stream_controller.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_stream_controller.sv
// des_stream_controller: key load, block issue and result-write
// tracking around a fixed-latency pipelined DES core.
module des_stream_controller #(
  parameter int PIPE_LATENCY = 16,
  parameter int OUT_DEPTH    = 64,
  parameter int BLOCK_WIDTH  = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stop,
  input  logic [BLOCK_WIDTH-1:0]     key_in,
  input  logic                       mode_in,
  input  logic                       in_empty,
  output logic                       in_read_enable,
  input  logic [BLOCK_WIDTH-1:0]     in_read_data,
  output logic                       des_valid,
  output logic [BLOCK_WIDTH-1:0]     des_data,
  output logic [BLOCK_WIDTH-1:0]     des_key,
  output logic                       des_mode,
  output logic                       key_load,
  output logic                       result_write,
  input  logic                       out_pop,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(OUT_DEPTH):0] inflight
);

  localparam int CW = $clog2(OUT_DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(OUT_DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    KEY_LOAD,
    RUN,
    DRAIN
  } state_t;

  state_t                  state;
  logic [CW-1:0]           credits;
  logic [PIPE_LATENCY-1:0] valid_sr;
  logic                    credit_ret;
  logic                    drained;

  assign in_read_enable = (state == RUN) && !in_empty
                        && (credits != '0) && !stop;
  assign credit_ret     = out_pop && (credits != FULL);
  assign des_data       = in_read_data;
  assign result_write   = valid_sr[PIPE_LATENCY-1];
  assign drained        = !des_valid && (valid_sr == '0)
                        && (inflight == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      des_key  <= '0;
      des_mode <= 1'b0;
      key_load <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      key_load <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        IDLE: begin
          busy <= start;
          if (start) begin
            des_key  <= key_in;
            des_mode <= mode_in;
            key_load <= 1'b1;
            state    <= KEY_LOAD;
          end
        end
        KEY_LOAD: state <= RUN;
        RUN: if (stop) state <= DRAIN;
        // busy stays high through the done cycle
        DRAIN: if (drained) begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      des_valid <= 1'b0;
      valid_sr  <= '0;
    end else begin
      des_valid   <= in_read_enable;
      valid_sr[0] <= des_valid;
      for (int i = 1; i < PIPE_LATENCY; i++)
        valid_sr[i] <= valid_sr[i-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      credits <= FULL;
    end else begin
      unique case ({in_read_enable, credit_ret})
        2'b10:   credits <= credits - ONE;
        2'b01:   credits <= credits + ONE;
        default: credits <= credits;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      unique case ({des_valid, result_write})
        2'b10:   inflight <= inflight + ONE;
        2'b01:   inflight <= inflight - ONE;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_des_stream_controller.sv
// tb_des_stream_controller: randomized stimulus against a
// cycle-indexed reference model of the stream controller.
module tb_des_stream_controller;

  localparam int L  = 8;
  localparam int D  = 16;
  localparam int W  = 64;
  localparam int CW = $clog2(D) + 1;
  localparam int NC = 8192;

  logic          clock = 1'b0;
  logic          reset, start, stop, mode_in, in_empty;
  logic          in_read_enable, des_valid, des_mode;
  logic          key_load, result_write, out_pop, busy, done;
  logic [W-1:0]  key_in, in_read_data, des_data, des_key;
  logic [CW-1:0] inflight;

  always #5 clock = ~clock;

  des_stream_controller #(
    .PIPE_LATENCY(L),
    .OUT_DEPTH(D),
    .BLOCK_WIDTH(W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .stop(stop),
    .key_in(key_in),
    .mode_in(mode_in),
    .in_empty(in_empty),
    .in_read_enable(in_read_enable),
    .in_read_data(in_read_data),
    .des_valid(des_valid),
    .des_data(des_data),
    .des_key(des_key),
    .des_mode(des_mode),
    .key_load(key_load),
    .result_write(result_write),
    .out_pop(out_pop),
    .busy(busy),
    .done(done),
    .inflight(inflight)
  );

  int n_chk = 0;
  int n_pass = 0;

  // environment: input FIFO contents, output FIFO occupancy
  logic [W-1:0] in_q[$];
  int out_cnt, consumer;
  int pops, dv_cnt, rw_cnt;

  // reference model, indexed by cycle number
  typedef enum {M_IDLE, M_KEY, M_RUN, M_DRAIN} ph_t;
  ph_t          ph;
  int           cyc, credits;
  bit           popped[NC];
  logic [W-1:0] pdata[NC];
  logic [W-1:0] m_key;
  bit           m_mode, m_done;

  task automatic check(string tag, logic [W-1:0] got,
                       logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)",
                  tag, got, exp, cyc);
  endtask

  function automatic bit pop_at(int c);
    return (c >= 0 && c < NC) ? popped[c] : 1'b0;
  endfunction

  function automatic bit exp_re();
    return ph == M_RUN && !in_empty && credits > 0 && !stop;
  endfunction

  function automatic int exp_inflight(int c);
    int s = 0;
    for (int k = c - 1 - L; k <= c - 2; k++) s += int'(pop_at(k));
    return s;
  endfunction

  function automatic bit quiet_since(int lo, int hi);
    bit q = 1'b1;
    for (int k = lo; k <= hi; k++) if (pop_at(k)) q = 1'b0;
    return q;
  endfunction

  task automatic model_reset();
    ph      = M_IDLE;
    credits = D;
    popped  = '{default: 1'b0};
    m_key   = '0;
    m_mode  = 1'b0;
    m_done  = 1'b0;
    out_cnt = 0;
  endtask

  task automatic model_step(bit mp);
    int c = cyc;
    popped[c] = mp;
    if (mp) pdata[c] = in_q[0];
    credits = credits - int'(mp)
            + ((out_pop && credits != D) ? 1 : 0);
    m_done = 1'b0;
    case (ph)
      M_IDLE: if (start) begin
        ph = M_KEY; m_key = key_in; m_mode = mode_in;
      end
      M_KEY: ph = M_RUN;
      M_RUN: if (stop) ph = M_DRAIN;
      M_DRAIN: if (quiet_since(c - 1 - L, c - 1)) begin
        ph = M_IDLE; m_done = 1'b1;
      end
      default: ph = M_IDLE;
    endcase
  endtask

  task automatic check_outputs();
    bit dv = pop_at(cyc - 1);
    check("des_valid", W'(des_valid), W'(dv));
    if (dv) check("des_data", des_data, pdata[cyc-1]);
    check("result_write", W'(result_write),
          W'(pop_at(cyc - 1 - L)));
    check("inflight", W'(inflight), W'(exp_inflight(cyc)));
    check("key_load", W'(key_load), W'(ph == M_KEY));
    check("busy", W'(busy), W'(ph != M_IDLE || m_done));
    check("done", W'(done), W'(m_done));
    check("des_key", des_key, m_key);
    check("des_mode", W'(des_mode), W'(m_mode));
  endtask

  task automatic tick();
    bit mp, dp, rw, op;
    case (consumer)
      1: out_pop = (out_cnt > 0);
      2: out_pop = (out_cnt > 0) && ($urandom_range(0, 1) == 1);
      3: out_pop = 1'b1;
      default: out_pop = 1'b0;
    endcase
    #1;
    if (reset) model_reset();
    mp = exp_re();
    dp = in_read_enable;
    rw = result_write;
    op = out_pop;
    check("in_read_enable", W'(dp), W'(mp));
    @(posedge clock);
    if (reset) model_reset();
    else model_step(mp);
    cyc++;
    if (dp && !reset && in_q.size() > 0) begin
      in_read_data = in_q.pop_front();
      pops++;
    end
    if (!reset) begin
      if (op && out_cnt > 0) out_cnt--;
      if (rw) out_cnt++;
    end
    @(negedge clock);
    check_outputs();
    if (des_valid) dv_cnt++;
    if (result_write) rw_cnt++;
    in_empty = (in_q.size() == 0);
  endtask

  task automatic push(int n);
    for (int i = 0; i < n; i++)
      in_q.push_back({$urandom, $urandom});
    in_empty = (in_q.size() == 0);
  endtask

  task automatic pulse_start(logic [W-1:0] k, bit m);
    start = 1'b1; key_in = k; mode_in = m;
    tick();
    start = 1'b0;
  endtask

  task automatic stop_and_drain(string tag);
    int n = 0;
    bit seen = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    while (!seen && n < 60) begin
      tick();
      seen = done;
      n++;
    end
    check(tag, W'(seen), W'(1));
    tick();
  endtask

  int base, base2;

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    key_in = '0; mode_in = 1'b0; out_pop = 1'b0;
    in_empty = 1'b1; in_read_data = '0;
    consumer = 0; cyc = 0; pops = 0; dv_cnt = 0; rw_cnt = 0;
    model_reset();
    @(negedge clock);
    tick(); tick();
    reset = 1'b0;

    // out_pop at full credits and stop in IDLE are ignored
    consumer = 3;
    repeat (3) tick();
    consumer = 0;
    stop = 1'b1; tick(); stop = 1'b0;

    // streaming, with start/stop ignored outside IDLE/RUN
    push(20);
    consumer = 1;
    base = dv_cnt; base2 = rw_cnt;
    pulse_start(64'h133457799BBCDFF1, 1'b0);
    start = 1'b1; stop = 1'b1; key_in = {$urandom, $urandom};
    mode_in = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    start = 1'b0;
    repeat (40) tick();
    check("stream_dv", W'(dv_cnt - base), W'(20));
    check("stream_rw", W'(rw_cnt - base2), W'(20));
    check("key_kept", des_key, 64'h133457799BBCDFF1);
    stop_and_drain("stream_done");

    // stop three cycles after first pop
    push(10);
    pulse_start({$urandom, $urandom}, 1'b1);
    tick();
    base = pops;
    repeat (3) tick();
    check("stop_pops", W'(pops - base), W'(3));
    stop_and_drain("stop_done");

    // backpressure: credits bound issue to output FIFO depth
    while (out_cnt > 0) tick();
    consumer = 0;
    push(30);
    base = pops;
    pulse_start({$urandom, $urandom}, 1'b0);
    repeat (40) tick();
    check("bp_pops", W'(pops - base), W'(D));
    consumer = 3; tick(); consumer = 0;
    repeat (20) tick();
    check("bp_one_more", W'(pops - base), W'(D + 1));
    stop_and_drain("bp_done");

    // pop and out_pop together at credits==1
    consumer = 3; tick(); consumer = 0;
    pulse_start({$urandom, $urandom}, 1'b1);
    tick();
    consumer = 1;
    base = pops;
    repeat (6) tick();
    check("credit1_pops", W'(pops - base), W'(6));
    stop_and_drain("credit1_done");

    // randomized runs
    for (int r = 0; r < 8; r++) begin
      consumer = 2;
      push($urandom_range(0, 8));
      pulse_start({$urandom, $urandom}, 1'($urandom_range(0, 1)));
      for (int k = 0; k < int'($urandom_range(10, 60)); k++) begin
        if ($urandom_range(0, 1) == 1) push(1);
        tick();
      end
      stop_and_drain("rand_done");
    end

    // reset mid-RUN with results in flight
    consumer = 1;
    while (out_cnt > 0) tick();
    push(10);
    pulse_start({$urandom, $urandom}, 1'b0);
    tick();
    base = pops;
    for (int k = 0; k < 20 && pops - base < 5; k++) tick();
    check("pre_reset_pops", W'(pops - base), W'(5));
    reset = 1'b1;
    #1;
    check("rst_des_valid", W'(des_valid), W'(0));
    check("rst_result_write", W'(result_write), W'(0));
    check("rst_inflight", W'(inflight), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_des_key", des_key, '0);
    check("rst_re", W'(in_read_enable), W'(0));
    tick(); tick();
    reset = 1'b0;
    base2 = rw_cnt;
    repeat (30) tick();
    check("post_reset_rw", W'(rw_cnt - base2), W'(0));

    // credits back at full depth after reset
    consumer = 0;
    push(30);
    base = pops;
    pulse_start({$urandom, $urandom}, 1'b1);
    repeat (40) tick();
    check("rst_credits", W'(pops - base), W'(D));
    stop_and_drain("final_done");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
